// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single-port external SRAM between instruction fetch and the MEM stage,
// sequencing each access with a wait-state down-counter and alternating priority on ties.
module mem_bus_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ADDR_W      = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ack,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [3:0]        mem_sel,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_ack,
    output logic              stallreq_if,
    output logic              stallreq_mem,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [3:0]        ram_sel,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);
    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_MEM = 1'b1;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic        kill_if_q, kill_if_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;

    logic if_elig, grant_mem, grant_if;
    logic unused_addr;

    assign if_elig   = if_req & ~flush;
    assign grant_mem = mem_req & (~if_elig | (last_q == OWN_IF));
    assign grant_if  = if_elig & ~grant_mem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            owner_q     <= OWN_IF;
            last_q      <= OWN_IF;
            kill_if_q   <= 1'b0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            wdata_q     <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            kill_if_q   <= kill_if_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            wdata_q     <= wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        last_d      = last_q;
        kill_if_d   = 1'b0;
        addr_d      = addr_q;
        we_d        = we_q;
        sel_d       = sel_q;
        wdata_d     = wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        case (state_q)
            IDLE: begin
                if (grant_mem) begin
                    owner_d = OWN_MEM;
                    last_d  = OWN_MEM;
                    addr_d  = mem_addr;
                    we_d    = mem_we;
                    sel_d   = mem_sel;
                    wdata_d = mem_wdata;
                    cnt_d   = CNT_INIT;
                    state_d = BUSY;
                end else if (grant_if) begin
                    owner_d = OWN_IF;
                    last_d  = OWN_IF;
                    addr_d  = if_addr;
                    we_d    = 1'b0;
                    sel_d   = 4'b1111;
                    wdata_d = '0;
                    cnt_d   = CNT_INIT;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                cnt_d     = cnt_q - 4'd1;
                kill_if_d = (owner_q == OWN_IF) & (flush | kill_if_q);
                if (cnt_q == 4'd1) begin
                    state_d = ACK;
                    if (!we_q) begin
                        if (owner_q == OWN_MEM) mem_rdata_d = ram_rdata;
                        else                    if_rdata_d  = ram_rdata;
                    end
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A flush arriving in the ACK cycle itself must also swallow the IF pulse.
    assign if_ack  = (state_q == ACK) & (owner_q == OWN_IF) & ~kill_if_q & ~flush;
    assign mem_ack = (state_q == ACK) & (owner_q == OWN_MEM);

    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;

    assign stallreq_if  = if_req & ~if_ack & ~flush;
    assign stallreq_mem = mem_req & ~mem_ack;

    assign ram_ce    = (state_q == BUSY);
    assign ram_we    = ram_ce & we_q;
    assign ram_sel   = ram_ce ? sel_q : 4'b0000;
    assign ram_addr  = ram_ce ? addr_q[ADDR_W+1:2] : '0;
    assign ram_wdata = ram_ce ? wdata_q : 32'h0;

    assign unused_addr = &{1'b0, addr_q};

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (WAIT_CYCLES=2 main instance, WAIT_CYCLES=1 second instance).
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        mem_req = 1'b0, mem_we = 1'b0;
    logic [3:0]  mem_sel = 4'b1111;
    logic [31:0] mem_addr = '0, mem_wdata = '0, ram_rdata = '0;

    logic [31:0] if_rdata, mem_rdata, ram_wdata;
    logic        if_ack, mem_ack, stallreq_if, stallreq_mem, ram_ce, ram_we;
    logic [3:0]  ram_sel;
    logic [19:0] ram_addr;

    logic        if_req2 = 1'b0, mem_req2 = 1'b0;
    logic [31:0] if_rdata2, mem_rdata2, ram_wdata2;
    logic        if_ack2, mem_ack2, stallreq_if2, stallreq_mem2, ram_ce2, ram_we2;
    logic [3:0]  ram_sel2;
    logic [19:0] ram_addr2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.WAIT_CYCLES(2), .ADDR_W(20)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_sel(ram_sel), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    mem_bus_arbiter #(.WAIT_CYCLES(1), .ADDR_W(20)) dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .if_req(if_req2), .if_addr(if_addr), .if_rdata(if_rdata2), .if_ack(if_ack2),
        .mem_req(mem_req2), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata2), .mem_ack(mem_ack2),
        .stallreq_if(stallreq_if2), .stallreq_mem(stallreq_mem2),
        .ram_ce(ram_ce2), .ram_we(ram_we2), .ram_sel(ram_sel2), .ram_addr(ram_addr2),
        .ram_wdata(ram_wdata2), .ram_rdata(ram_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #1 rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        // Reset state
        tick();
        chk("rst_ram_ce", 32'(ram_ce), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_if_ack", 32'(if_ack), 32'd0);
        chk("rst_mem_ack", 32'(mem_ack), 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        rst = 1'b1;

        // Single MEM read
        mem_req = 1'b1; mem_addr = 32'h10; ram_rdata = 32'hDEADBEEF;
        tick();
        chk("rd_ce1", 32'(ram_ce), 32'd1);
        chk("rd_addr", 32'(ram_addr), 32'h4);
        chk("rd_we", 32'(ram_we), 32'd0);
        chk("rd_stall_busy", 32'(stallreq_mem), 32'd1);
        chk("rd_ack_early", 32'(mem_ack), 32'd0);
        tick();
        chk("rd_ce2", 32'(ram_ce), 32'd1);
        tick();
        chk("rd_ce_ack", 32'(ram_ce), 32'd0);
        chk("rd_ack", 32'(mem_ack), 32'd1);
        chk("rd_rdata", mem_rdata, 32'hDEADBEEF);
        chk("rd_stall_ack", 32'(stallreq_mem), 32'd0);
        mem_req = 1'b0;
        tick();
        chk("rd_ack_one", 32'(mem_ack), 32'd0);
        chk("rd_rdata_hold", mem_rdata, 32'hDEADBEEF);

        // Simultaneous requests after reset: MEM, then IF, then MEM again
        do_reset();
        if_req = 1'b1; if_addr = 32'h100; mem_req = 1'b1; mem_addr = 32'h200;
        tick();
        chk("tie1_addr", 32'(ram_addr), 32'h80);
        chk("tie1_stall_if", 32'(stallreq_if), 32'd1);
        tick(); tick();
        chk("tie1_mem_ack", 32'(mem_ack), 32'd1);
        chk("tie1_if_ack", 32'(if_ack), 32'd0);
        mem_req = 1'b0; ram_rdata = 32'h12345678;
        tick();
        chk("tie_idle_ce", 32'(ram_ce), 32'd0);
        tick();
        chk("tie2_addr", 32'(ram_addr), 32'h40);
        tick(); tick();
        chk("if_ack", 32'(if_ack), 32'd1);
        chk("if_rdata", if_rdata, 32'h12345678);
        chk("if_stall_ack", 32'(stallreq_if), 32'd0);
        if_addr = 32'h104; mem_req = 1'b1; mem_addr = 32'h300; ram_rdata = 32'h55AA55AA;
        tick();
        chk("no_regrant_ack", 32'(ram_ce), 32'd0);
        tick();
        chk("tie3_addr", 32'(ram_addr), 32'hC0);
        tick(); tick();
        chk("tie3_mem_ack", 32'(mem_ack), 32'd1);
        chk("tie3_rdata", mem_rdata, 32'h55AA55AA);
        mem_req = 1'b0;
        tick(); tick();
        chk("tie4_addr", 32'(ram_addr), 32'h41);
        tick(); tick();
        chk("tie4_if_ack", 32'(if_ack), 32'd1);
        if_req = 1'b0;
        tick();

        // Byte write
        mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'b0100; mem_wdata = 32'h00AB0000;
        mem_addr = 32'h20; ram_rdata = 32'hCAFEF00D;
        tick();
        chk("wr_we1", 32'(ram_we), 32'd1);
        chk("wr_sel", 32'(ram_sel), 32'h4);
        chk("wr_wdata", ram_wdata, 32'h00AB0000);
        chk("wr_addr", 32'(ram_addr), 32'h8);
        tick();
        chk("wr_we2", 32'(ram_we), 32'd1);
        tick();
        chk("wr_ack", 32'(mem_ack), 32'd1);
        chk("wr_we_ack", 32'(ram_we), 32'd0);
        chk("wr_rdata_keep", mem_rdata, 32'h55AA55AA);
        mem_req = 1'b0; mem_we = 1'b0; mem_sel = 4'b1111; mem_wdata = '0;
        tick();
        chk("wr_ack_one", 32'(mem_ack), 32'd0);

        // Flush during IF fetch with MEM pending
        if_req = 1'b1; if_addr = 32'h80;
        tick();
        chk("fl_ce1", 32'(ram_ce), 32'd1);
        chk("fl_addr", 32'(ram_addr), 32'h20);
        flush = 1'b1; mem_req = 1'b1; mem_addr = 32'h40;
        tick();
        chk("fl_ce2", 32'(ram_ce), 32'd1);
        flush = 1'b0;
        tick();
        chk("fl_ce_ack", 32'(ram_ce), 32'd0);
        chk("fl_if_ack", 32'(if_ack), 32'd0);
        chk("fl_stall_if", 32'(stallreq_if), 32'd1);
        if_req = 1'b0;
        tick();
        chk("fl_idle", 32'(ram_ce), 32'd0);
        chk("fl_if_ack_idle", 32'(if_ack), 32'd0);
        tick();
        chk("fl_mem_grant", 32'(ram_ce), 32'd1);
        chk("fl_mem_addr", 32'(ram_addr), 32'h10);
        tick(); tick();
        chk("fl_mem_ack", 32'(mem_ack), 32'd1);
        mem_req = 1'b0;
        tick();

        // Reset mid-access
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h8;
        tick();
        chk("rm_ce", 32'(ram_ce), 32'd1);
        chk("rm_we", 32'(ram_we), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("rm_ce_now", 32'(ram_ce), 32'd0);
        chk("rm_we_now", 32'(ram_we), 32'd0);
        tick(); tick(); tick();
        chk("rm_mem_ack", 32'(mem_ack), 32'd0);
        chk("rm_if_ack", 32'(if_ack), 32'd0);
        mem_we = 1'b0; mem_addr = 32'hC; ram_rdata = 32'h0BADCAFE;
        rst = 1'b1;
        tick();
        chk("rm2_addr", 32'(ram_addr), 32'h3);
        tick(); tick();
        chk("rm2_ack", 32'(mem_ack), 32'd1);
        chk("rm2_rdata", mem_rdata, 32'h0BADCAFE);
        mem_req = 1'b0;
        tick();

        // WAIT_CYCLES=1 back-to-back
        mem_req2 = 1'b1;
        tick();
        chk("w1_ce_a", 32'(ram_ce2), 32'd1);
        chk("w1_ack_a0", 32'(mem_ack2), 32'd0);
        tick();
        chk("w1_ack_a", 32'(mem_ack2), 32'd1);
        chk("w1_ce_a_off", 32'(ram_ce2), 32'd0);
        chk("w1_rdata", mem_rdata2, 32'h0BADCAFE);
        tick();
        chk("w1_idle_ack", 32'(mem_ack2), 32'd0);
        chk("w1_idle_ce", 32'(ram_ce2), 32'd0);
        tick();
        chk("w1_ce_b", 32'(ram_ce2), 32'd1);
        chk("w1_ack_b0", 32'(mem_ack2), 32'd0);
        tick();
        chk("w1_ack_b", 32'(mem_ack2), 32'd1);
        mem_req2 = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single-port external SRAM between instruction fetch (IF) and the MEM stage.
- Sequences each multi-cycle SRAM access with a wait-state counter.
- Raises stall requests to the pipeline controller, which drives stall[5:0] to the stage registers, until each requester's access completes.
- Sits between the IF/MEM stages and the SRAM pins.

Parameters:
- WAIT_CYCLES, 2, cycles ram_ce is held per access before read data is captured; legal range 1..15.
- ADDR_W, 20, SRAM word-address width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low
- flush  in  1  exception flush; cancels IF service
- if_req  in  1  IF fetch request; held with if_addr until if_ack
- if_addr  in  32  fetch byte address
- if_rdata  out  32  fetched instruction; valid while if_ack=1
- if_ack  out  1  one-cycle completion pulse to IF
- mem_req  in  1  MEM access request; held with its qualifiers until mem_ack
- mem_we  in  1  1 = write, 0 = read
- mem_sel  in  4  byte enables
- mem_addr  in  32  byte address
- mem_wdata  in  32  write data
- mem_rdata  out  32  read data; valid while mem_ack=1
- mem_ack  out  1  one-cycle completion pulse to MEM
- stallreq_if  out  1  IF stall request to the pipeline controller
- stallreq_mem  out  1  MEM stall request to the pipeline controller
- ram_ce  out  1  SRAM chip enable, active-high
- ram_we  out  1  SRAM write enable, active-high
- ram_sel  out  4  SRAM byte enables
- ram_addr  out  ADDR_W  SRAM word address
- ram_wdata  out  32  SRAM write data
- ram_rdata  in  32  SRAM read data

Behaviour:
- Reset: rst=0 forces the following immediately, regardless of clk, and holds them while rst=0:
  - state=IDLE, cnt=0, owner=IF, last_owner=IF.
  - Every registered output = 0.
  - Any access in flight is abandoned and no ack is issued.
- States: IDLE, BUSY, ACK.
- IDLE, arbitration at the clock edge:
  - Eligible requesters: mem_req; if_req only when flush=0.
  - One eligible requester: grant it.
  - Both eligible: grant the one that is not last_owner (alternating priority). After reset MEM wins the first tie.
- IDLE, on grant:
  - Latch the owner and address; also latch we, sel and wdata (IF: we=0, sel=4'b1111).
  - Set cnt=WAIT_CYCLES, update last_owner, go to BUSY.
- BUSY:
  - ram_ce=1; ram_addr = latched addr[ADDR_W+1:2].
  - ram_we, ram_sel and ram_wdata come from the latched values.
  - cnt decrements each edge.
  - At the edge where cnt==1: capture ram_rdata into the owner's rdata register (reads only) and go to ACK.
- ACK:
  - Owner's ack=1 for exactly this cycle; ram_ce=0.
  - Unconditionally go to IDLE. A held req is never re-granted in the ACK cycle.
- Latency:
  - A request sampled at edge E gets its ack high for the cycle following edge E+WAIT_CYCLES.
  - Minimum spacing between grants is WAIT_CYCLES+2 cycles.
- Write accesses: the ack timing is identical to reads; mem_rdata keeps its previous value.
- Stall requests (combinational):
  - stallreq_X = X_req & ~X_ack.
  - stallreq_if is additionally forced to 0 while flush=1.
- flush:
  - Never aborts an SRAM cycle already in BUSY.
  - If the owner is IF and flush is seen in BUSY or ACK, the flag kill_if is set and if_ack is suppressed for that access.
  - kill_if clears on return to IDLE.
- Requester protocol:
  - Dropping req before ack is a protocol violation; the access still completes and ack still pulses.
  - Changing the address mid-access has no effect (values are latched).
- rdata registers hold their last captured value until the next read completes for the same port.
- ram_* outputs are 0 in IDLE and ACK, so there are no spurious writes.

Test Plan:
- Single MEM read, WAIT_CYCLES=2: mem_req=1, mem_addr=0x00000010, ram_rdata=0xDEADBEEF -> ram_ce high for 2 cycles with ram_addr=0x4, ram_we=0; mem_ack high 1 cycle with mem_rdata=0xDEADBEEF; stallreq_mem falls in that same cycle.
- Simultaneous requests after reset: if_req=1 (addr 0x100) and mem_req=1 (addr 0x200) -> MEM served first (ram_addr=0x80); IF served next (ram_addr=0x40). A second tie after that goes to MEM again, because last_owner=IF.
- Byte write: mem_we=1, mem_sel=4'b0100, mem_wdata=0x00AB0000 -> ram_we=1 and ram_sel=4'b0100 for 2 cycles; mem_ack pulses once; mem_rdata unchanged.
- Flush during an IF fetch: flush=1 for 1 cycle while in BUSY -> the SRAM cycle completes (ram_ce still 2 cycles) and if_ack stays 0; a pending mem_req is granted in the following IDLE cycle.
- Reset mid-access: rst=0 during BUSY -> ram_ce, ram_we, if_ack and mem_ack all go 0 immediately with no ack; after release, a fresh request completes normally.
- WAIT_CYCLES=1: back-to-back MEM requests -> acks 3 cycles apart; ram_ce high exactly 1 cycle per access.
